// File: rtl/pipe_pkg.sv
// Shared types and constants for the two-entry pipeline skid buffer.
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'b00,
    PIPE_BUSY  = 2'b01,
    PIPE_FULL  = 2'b10
  } pipe_state_t;

  localparam int unsigned PIPE_DEPTH = 2;

  // Number of valid entries held in a given state.
  function automatic int unsigned pipe_occupancy(input pipe_state_t s);
    case (s)
      PIPE_BUSY: pipe_occupancy = 1;
      PIPE_FULL: pipe_occupancy = 2;
      default:   pipe_occupancy = 0;
    endcase
  endfunction

endpackage

// File: rtl/mux_2_to_1.sv
// Two-input word multiplexer: y = sel ? b : a.
module mux_2_to_1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready pipeline register with a skid entry and registered in_ready.
// Optional synchronous flush port is enabled by defining PIPE_FLUSH_EN.
module pipe_skid_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PIPE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  pipe_state_t      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q;
  logic             main_ld, skid_ld;
  logic             accept, pop;

  assign accept = in_valid && in_ready_q;
  assign pop    = out_valid_q && out_ready;

  // In FULL the head is refilled from the skid entry, otherwise from upstream.
  mux_2_to_1 #(.WIDTH(WIDTH)) u_main_mux (
    .a   (in_data),
    .b   (skid_q),
    .sel (state_q == PIPE_FULL),
    .y   (main_d)
  );

  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    case (state_q)
      PIPE_EMPTY: begin
        if (accept) begin
          state_d = PIPE_BUSY;
          main_ld = 1'b1;
        end
      end
      PIPE_BUSY: begin
        if (accept && pop) begin
          main_ld = 1'b1;
        end else if (accept) begin
          state_d = PIPE_FULL;
          skid_ld = 1'b1;
        end else if (pop) begin
          state_d = PIPE_EMPTY;
        end
      end
      PIPE_FULL: begin
        if (pop) begin
          state_d = PIPE_BUSY;
          main_ld = 1'b1;
        end
      end
      default: state_d = PIPE_EMPTY;
    endcase
`ifdef PIPE_FLUSH_EN
    // Flush drops both entries and any offered word; out_data keeps its value.
    if (flush) begin
      state_d = PIPE_EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
`endif
    out_valid_d = (state_d != PIPE_EMPTY);
    in_ready_d  = (state_d != PIPE_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PIPE_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
    end else if (main_ld) begin
      main_q <= main_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q <= '0;
    end else if (skid_ld) begin
      skid_q <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  a_full_not_ready: assert property (@(posedge clk) disable iff (rst)
    (state_q == PIPE_FULL) |-> !in_ready_q);
  a_depth: assert property (@(posedge clk) disable iff (rst)
    pipe_occupancy(state_q) <= PIPE_DEPTH);
  a_valid_match: assert property (@(posedge clk) disable iff (rst)
    out_valid_q == (state_q != PIPE_EMPTY));

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: directed scenarios plus random traffic vs a queue model.
module tb_pipe_skid_buffer;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int total = 0;
  int bad   = 0;

  // Reference model: a FIFO of at most PIPE_DEPTH words.
  logic [31:0] mq[$];
  logic [31:0] m_last;
  logic        m_ready;
  logic        m_acc;

  always #5 clk = ~clk;

  pipe_skid_buffer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PIPE_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Drive one cycle of inputs, advance the model across the edge, leave time #1 past the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic r,
                      input logic f, input logic rs);
    logic pop;
    in_valid = v; in_data = d; out_ready = r; flush = f; rst = rs;
    @(posedge clk);
    m_acc = 1'b0;
    if (rs) begin
      mq.delete(); m_last = '0; m_ready = 1'b1;
`ifdef PIPE_FLUSH_EN
    end else if (f) begin
      mq.delete(); m_ready = 1'b1;
`endif
    end else begin
      m_acc = v && m_ready;
      pop   = (mq.size() > 0) && r;
      if (pop) void'(mq.pop_front());
      if (m_acc) mq.push_back(d);
      if (mq.size() > 0) m_last = mq[0];
      m_ready = (mq.size() < int'(PIPE_DEPTH));
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
      bad++;
      $display("FAIL reset: got v=%b r=%b d=%h want v=0 r=1 d=0", out_valid, in_ready, out_data);
    end
  endtask

  task automatic test_stream();
    logic [31:0] din[4]  = '{32'h11, 32'h22, 32'h33, 32'h0};
    logic        vin[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        vexp[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(vin[i], din[i], 1'b1, 1'b0, 1'b0);
      total++;
      if (out_valid !== vexp[i] || in_ready !== 1'b1 || (vexp[i] && out_data !== din[i])
          || out_data !== m_last) begin
        bad++;
        $display("FAIL stream[%0d]: got v=%b r=%b d=%h want v=%b r=1 d=%h",
                 i, out_valid, in_ready, out_data, vexp[i], m_last);
      end
    end
  endtask

  task automatic test_stall();
    logic        vin[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] din[6]  = '{32'hA0, 32'hA1, 32'hA2, 32'hA2, 32'hA2, 32'h0};
    logic        rin[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] dexp[6] = '{32'hA0, 32'hA0, 32'hA0, 32'hA1, 32'hA2, 32'hA2};
    logic        vexp[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        rexp[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      step(vin[i], din[i], rin[i], 1'b0, 1'b0);
      total++;
      if (out_valid !== vexp[i] || in_ready !== rexp[i] || out_data !== dexp[i]
          || out_valid !== (mq.size() > 0) || in_ready !== m_ready) begin
        bad++;
        $display("FAIL stall[%0d]: got v=%b r=%b d=%h want v=%b r=%b d=%h",
                 i, out_valid, in_ready, out_data, vexp[i], rexp[i], dexp[i]);
      end
    end
  endtask

  task automatic test_simul();
    logic        vin[3]  = '{1'b1, 1'b1, 1'b0};
    logic [31:0] din[3]  = '{32'h5, 32'h6, 32'h0};
    logic        rin[3]  = '{1'b0, 1'b1, 1'b1};
    logic        vexp[3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] dexp[3] = '{32'h5, 32'h6, 32'h6};
    for (int i = 0; i < 3; i++) begin
      step(vin[i], din[i], rin[i], 1'b0, 1'b0);
      total++;
      if (out_valid !== vexp[i] || in_ready !== 1'b1 || out_data !== dexp[i]) begin
        bad++;
        $display("FAIL simul[%0d]: got v=%b r=%b d=%h want v=%b r=1 d=%h",
                 i, out_valid, in_ready, out_data, vexp[i], dexp[i]);
      end
    end
  endtask

  task automatic test_reset_full();
    step(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0);
    total++;
    if (in_ready !== 1'b0 || out_data !== 32'hB0) begin
      bad++;
      $display("FAIL rst_full_pre: got r=%b d=%h want r=0 d=b0", in_ready, out_data);
    end
    step(1'b1, 32'hB2, 1'b1, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_full: got v=%b r=%b d=%h want v=0 r=1 d=0", out_valid, in_ready, out_data);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0 || out_data === 32'hB2) begin
      bad++;
      $display("FAIL rst_full_post: got v=%b d=%h want v=0 d!=b2", out_valid, out_data);
    end
  endtask

`ifdef PIPE_FLUSH_EN
  task automatic test_flush();
    step(1'b1, 32'hC0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC2, 1'b1, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'hC0) begin
      bad++;
      $display("FAIL flush: got v=%b r=%b d=%h want v=0 r=1 d=c0", out_valid, in_ready, out_data);
    end
    step(1'b1, 32'hC3, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hC3) begin
      bad++;
      $display("FAIL flush_c3: got v=%b d=%h want v=1 d=c3", out_valid, out_data);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_end: got v=%b want v=0", out_valid);
    end
  endtask
`endif

  task automatic test_random();
    logic        pv = 1'b0;
    logic [31:0] pd = '0;
    logic        f, rs;
    for (int i = 0; i < 600; i++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        pd = $urandom();
      end
      rs = ($urandom_range(0, 99) == 0);
`ifdef PIPE_FLUSH_EN
      f = ($urandom_range(0, 49) == 0);
`else
      f = 1'b0;
`endif
      step(pv, pd, 1'($urandom_range(0, 1)), f, rs);
      if (m_acc || rs || f) pv = 1'b0;
      total++;
      if (out_valid !== (mq.size() > 0) || in_ready !== m_ready || out_data !== m_last) begin
        bad++;
        $display("FAIL random[%0d]: got v=%b r=%b d=%h want v=%b r=%b d=%h",
                 i, out_valid, in_ready, out_data, mq.size() > 0, m_ready, m_last);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    mq.delete(); m_last = '0; m_ready = 1'b1; m_acc = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_simul();
    test_reset_full();
`ifdef PIPE_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
